pmem_responder: RTL
===================

# pmem_responder

Physical-memory responder sitting on the far side of the L1 cache's pmem port: it accepts single-line (128-bit) read and write requests from `l1_cache_control`'s datapath and answers each with a one-cycle `pmem_resp`. A one-entry posted write buffer acknowledges write-backs quickly and drains to the backing array in the background. Reads that hit the buffered line are forwarded. It is the synthesizable replacement for the behavioural memory model used on the cache bench.

## Interface
- `LINE_AW`, 12, line-address width; the array holds 2^LINE_AW lines of 16 bytes.
- `READ_LAT`, 4, array read latency in cycles, ≥1.
- `WRITE_LAT`, 4, buffer drain time in cycles, ≥1.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pmem_read`  in  1  line read request, held until `pmem_resp`.
- `pmem_write`  in  1  line write request, held until `pmem_resp`.
- `pmem_address`  in  16  byte address; bits [3:0] ignored, bits [LINE_AW+3:4] select the line.
- `pmem_wdata`  in  128  write line, valid while `pmem_write`.
- `pmem_rdata`  out  128  read line, valid in the `pmem_resp` cycle of a read.
- `pmem_resp`  out  1  one-cycle completion pulse.

## Operation
- Request FSM states: IDLE, RD_BUSY, RESP.
- IDLE, `pmem_write`=1, `wb_valid`=0: capture line address and `pmem_wdata` into the buffer and go to RESP.
- IDLE, `pmem_write`=1, `wb_valid`=1: stay in IDLE (stall). Accept in the first cycle with `wb_valid`=0.
- IDLE, `pmem_read`=1, buffer hit (`wb_valid` and line match): latch `wb_data` into the read register and go to RESP.
- IDLE, `pmem_read`=1, no hit: load the latency counter with READ_LAT-1 and go to RD_BUSY.
- Read and write both asserted: the write takes priority. The requester must never do this; the verifier flags it as an error.
- RD_BUSY: decrement the counter each cycle. On the cycle the counter is 0, latch read data and go to RESP.
  - Read data is `wb_data` if the buffer holds the same line in that cycle, including its commit cycle; otherwise it is `array[line]`.
- RESP: `pmem_resp`=1 for exactly one cycle, then IDLE. Requests are not sampled in RESP.
- Drain: starts the cycle after capture, independent of the request FSM. A counter runs WRITE_LAT-1 down to 0; at 0 the buffer is written to the array and `wb_valid` is cleared.
- The single array port is write-first. A read and a commit in the same cycle to the same line are resolved by the forwarding rule above.

## Timing
- Reset (async assert, sync deassert of internal state): state=IDLE, `pmem_resp`=0, `pmem_rdata`=0, `wb_valid`=0, both counters 0.
  - Array contents are not reset.
  - A buffered write pending at reset is lost; documented behaviour.
  - Reset mid-RD_BUSY aborts with no response.
- Read miss accepted in cycle T: `pmem_resp` in cycle T+READ_LAT+1.
- Read buffer-hit accepted in cycle T: `pmem_resp` in cycle T+1.
- Write accepted in cycle T: `pmem_resp` in T+1. Commit at the end of cycle T+WRITE_LAT; `wb_valid`=0 from T+WRITE_LAT+1.
- Back-to-back: a request asserted in the cycle after RESP is accepted in that cycle. This matches the cache's write-back-then-fill sequence.
- Write while the buffer is full: the earliest accept is cycle T+WRITE_LAT+1 after the previous capture at T. The response follows one cycle later.
- `pmem_rdata` holds its last value outside read responses.

## Structure
- `lc3b_types` additions: `lc3b_line` (128-bit) and `lc3b_pmem_addr` (16-bit), plus the state enum `pmem_resp_state_t`.
- Sub-module `pmem_write_buffer` holds the valid/addr/data registers, the drain counter, the hit compare, and the commit strobe.
- The top level holds the request FSM, the read latency counter, and the array.

## Test plan
- Cold read, addr 0x0120, array preloaded with line A, READ_LAT=4: request at T -> `pmem_resp` at T+5, `pmem_rdata`=A.
- Write 0x0120 with B at T, then read 0x0120 at T+2 -> write resp at T+1, read resp at T+3 with B (forwarded).
- Write B to 0x0120, read 0x0120 timed so the array read completes in the commit cycle -> data B, with no stale A.
- Two writes, 0x0200 then 0x0300, back-to-back -> second resp at T+WRITE_LAT+2; both lines read back correctly afterwards.
- Dirty-eviction pattern: write 0x0400, then an immediate read of 0x0500 in the cycle after RESP -> read accepted with no idle gap; correct data; write committed.
- Assert `rst_n`=0 during RD_BUSY and with `wb_valid`=1 -> no `pmem_resp`, outputs 0, a subsequent read returns the pre-write array value.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: cache line, pmem byte address and the pmem responder's
// request-FSM state encoding.
package lc3b_types;

    typedef logic [127:0] lc3b_line;
    typedef logic [15:0]  lc3b_pmem_addr;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BUSY = 2'd1,
        RESP    = 2'd2
    } pmem_resp_state_t;

endpackage

// File: rtl/pmem_write_buffer.sv
// One-entry posted write buffer: captures a line, counts down its drain time,
// then strobes commit for one cycle while it writes the line to the array.
module pmem_write_buffer
    import lc3b_types::*;
#(
    parameter int LINE_AW   = 12,
    parameter int WRITE_LAT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               capture,
    input  logic [LINE_AW-1:0] cap_line,
    input  lc3b_line           cap_data,
    input  logic [LINE_AW-1:0] lookup_line,
    output logic               wb_valid,
    output logic [LINE_AW-1:0] wb_line,
    output lc3b_line           wb_data,
    output logic               hit,
    output logic               commit
);

    localparam int DCW = $clog2(WRITE_LAT + 1);

    logic [DCW-1:0] drain_cnt;

    // The requester never captures while the entry is valid, so capture
    // simply overrides the drain path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid  <= 1'b0;
            wb_line   <= '0;
            wb_data   <= '0;
            drain_cnt <= '0;
        end else if (capture) begin
            wb_valid  <= 1'b1;
            wb_line   <= cap_line;
            wb_data   <= cap_data;
            drain_cnt <= DCW'(WRITE_LAT - 1);
        end else if (wb_valid) begin
            if (drain_cnt == '0) begin
                wb_valid <= 1'b0;
            end else begin
                drain_cnt <= drain_cnt - DCW'(1);
            end
        end
    end

    assign commit = wb_valid && (drain_cnt == '0);
    assign hit    = wb_valid && (wb_line == lookup_line);

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder for the L1 pmem port: request FSM, read latency
// counter and the line array, fronted by a posted write buffer.
module pmem_responder
    import lc3b_types::*;
#(
    parameter int LINE_AW   = 12,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pmem_read,
    input  logic             pmem_write,
    input  lc3b_pmem_addr    pmem_address,
    input  lc3b_line         pmem_wdata,
    output lc3b_line         pmem_rdata,
    output logic             pmem_resp,
    output pmem_resp_state_t dbg_state
);

    // Handshake: pmem_read/pmem_write stay high until the one-cycle pmem_resp;
    // a request is accepted only in IDLE, never sampled in RESP.

    localparam int RCW = $clog2(READ_LAT + 1);

    pmem_resp_state_t   state;
    logic [RCW-1:0]     rd_cnt;
    logic [LINE_AW-1:0] req_line;
    logic [LINE_AW-1:0] addr_line;
    logic [LINE_AW-1:0] lookup_line;
    lc3b_line           mem [2**LINE_AW];

    logic               capture;
    logic               wb_valid;
    logic [LINE_AW-1:0] wb_line;
    lc3b_line           wb_data;
    logic               wb_hit;
    logic               wb_commit;
    logic               unused_addr;

    assign addr_line   = pmem_address[LINE_AW+3:4];
    assign unused_addr = ^pmem_address;
    // While a miss is outstanding the buffer is compared against the latched line.
    assign lookup_line = (state == RD_BUSY) ? req_line : addr_line;
    assign capture     = (state == IDLE) && pmem_write && !wb_valid;
    assign dbg_state   = state;

    pmem_write_buffer #(
        .LINE_AW   (LINE_AW),
        .WRITE_LAT (WRITE_LAT)
    ) u_wbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture     (capture),
        .cap_line    (addr_line),
        .cap_data    (pmem_wdata),
        .lookup_line (lookup_line),
        .wb_valid    (wb_valid),
        .wb_line     (wb_line),
        .wb_data     (wb_data),
        .hit         (wb_hit),
        .commit      (wb_commit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            rd_cnt     <= '0;
            req_line   <= '0;
        end else begin
            pmem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (pmem_write) begin
                        if (!wb_valid) begin
                            state     <= RESP;
                            pmem_resp <= 1'b1;
                        end
                    end else if (pmem_read) begin
                        if (wb_hit) begin
                            pmem_rdata <= wb_data;
                            state      <= RESP;
                            pmem_resp  <= 1'b1;
                        end else begin
                            req_line <= addr_line;
                            rd_cnt   <= RCW'(READ_LAT - 1);
                            state    <= RD_BUSY;
                        end
                    end
                end
                RD_BUSY: begin
                    if (rd_cnt == '0) begin
                        // Forwarding covers a commit to this line in this same cycle.
                        pmem_rdata <= wb_hit ? wb_data : mem[req_line];
                        state      <= RESP;
                        pmem_resp  <= 1'b1;
                    end else begin
                        rd_cnt <= rd_cnt - RCW'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wb_commit) begin
            mem[wb_line] <= wb_data;
        end
    end

endmodule
